// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch predictor.
// The master drives fetch/resolve inputs; the slave (predictor) returns prediction and flush info.
interface branch_predictor_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] fetchPC;
   logic                  predictTaken;
   logic [DATA_WIDTH-1:0] predictTarget;
   logic                  resolveValid;
   logic [DATA_WIDTH-1:0] resolvePC;
   logic                  resolveTaken;
   logic [DATA_WIDTH-1:0] resolveTarget;
   logic                  resolvePredTaken;
   logic [DATA_WIDTH-1:0] resolvePredTarget;
   logic                  mispredict;
   logic [DATA_WIDTH-1:0] redirectPC;
   logic [31:0]           mispredictCount;

   modport master (
      output fetchPC, resolveValid, resolvePC, resolveTaken, resolveTarget,
             resolvePredTaken, resolvePredTarget,
      input  predictTaken, predictTarget, mispredict, redirectPC, mispredictCount
   );

   modport slave (
      input  fetchPC, resolveValid, resolvePC, resolveTaken, resolveTarget,
             resolvePredTaken, resolvePredTarget,
      output predictTaken, predictTarget, mispredict, redirectPC, mispredictCount
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with tagged BTB, trained by resolved execute outcomes.
// Lookup is combinational and sees pre-update table contents in the cycle of a write.
module branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic          clk,
   input  logic          rst,
   branch_predictor_if.slave bp
);
   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   logic                  valid_r  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_r    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_r [ENTRIES];
   logic [1:0]            ctr_r    [ENTRIES];
   logic [31:0]           count_r;

   logic [INDEX_BITS-1:0] fidx_s;
   logic [TAG_BITS-1:0]   ftag_s;
   logic [INDEX_BITS-1:0] ridx_s;
   logic [TAG_BITS-1:0]   rtag_s;
   logic                  fhit_s;
   logic                  rhit_s;
   logic                  ptaken_s;
   logic [DATA_WIDTH-1:0] ptarget_s;
   logic                  mispredict_s;
   logic [DATA_WIDTH-1:0] redirect_s;

   // Saturating step of a 2-bit direction counter.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         2'b00:   nxt = taken ? 2'b01 : 2'b00;
         2'b01:   nxt = taken ? 2'b10 : 2'b00;
         2'b10:   nxt = taken ? 2'b11 : 2'b01;
         2'b11:   nxt = taken ? 2'b11 : 2'b10;
         default: nxt = 2'b01;
      endcase
      return nxt;
   endfunction

   assign fidx_s = bp.fetchPC[INDEX_BITS+1:2];
   assign ftag_s = bp.fetchPC[DATA_WIDTH-1:INDEX_BITS+2];
   assign ridx_s = bp.resolvePC[INDEX_BITS+1:2];
   assign rtag_s = bp.resolvePC[DATA_WIDTH-1:INDEX_BITS+2];

   // Fetch-side lookup: direction and next-PC prediction.
   always_comb begin
      fhit_s    = 1'b0;
      ptaken_s  = 1'b0;
      ptarget_s = bp.fetchPC + PC_STEP;
      if (valid_r[fidx_s] && (tag_r[fidx_s] == ftag_s)) begin
         fhit_s = 1'b1;
      end else begin
         fhit_s = 1'b0;
      end
      ptaken_s = fhit_s && ctr_r[fidx_s][1];
      if (ptaken_s) begin
         ptarget_s = target_r[fidx_s];
      end else begin
         ptarget_s = bp.fetchPC + PC_STEP;
      end
   end

   // Resolve-side misprediction detection and redirect target.
   always_comb begin
      mispredict_s = 1'b0;
      redirect_s   = bp.resolvePC + PC_STEP;
      if (!bp.resolveValid) begin
         mispredict_s = 1'b0;
      end else if (bp.resolveTaken != bp.resolvePredTaken) begin
         mispredict_s = 1'b1;
      end else if (bp.resolveTaken && (bp.resolvePredTarget != bp.resolveTarget)) begin
         mispredict_s = 1'b1;
      end else begin
         mispredict_s = 1'b0;
      end
      if (bp.resolveTaken) begin
         redirect_s = bp.resolveTarget;
      end else begin
         redirect_s = bp.resolvePC + PC_STEP;
      end
   end

   assign rhit_s = valid_r[ridx_s] && (tag_r[ridx_s] == rtag_s);

   // Table training and misprediction counter; reset wins over a concurrent resolve.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_r[i] <= 1'b0;
            ctr_r[i]   <= 2'b01;
         end
         count_r <= 32'd0;
      end else begin
         if (bp.resolveValid) begin
            if (rhit_s) begin
               ctr_r[ridx_s] <= ctr_next(ctr_r[ridx_s], bp.resolveTaken);
               if (bp.resolveTaken) begin
                  target_r[ridx_s] <= bp.resolveTarget;
               end
            end else if (bp.resolveTaken) begin
               valid_r[ridx_s]  <= 1'b1;
               tag_r[ridx_s]    <= rtag_s;
               target_r[ridx_s] <= bp.resolveTarget;
               ctr_r[ridx_s]    <= 2'b10;
            end
         end
         if (mispredict_s) begin
            count_r <= count_r + 32'd1;
         end
      end
   end

   assign bp.predictTaken    = ptaken_s;
   assign bp.predictTarget   = ptarget_s;
   assign bp.mispredict      = mispredict_s;
   assign bp.redirectPC      = redirect_s;
   assign bp.mispredictCount = count_r;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a table-level reference model predicts each cycle's outputs, a negedge
// monitor pops and compares them against the predictor.
module tb_branch_predictor;
   localparam int NENT = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_predictor_if #(.DATA_WIDTH(32)) bif();

   branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bif.slave)
   );

   typedef struct {
      logic        ptaken;
      logic [31:0] ptarget;
      logic        misp;
      logic [31:0] redir;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int compared = 0;
   int mismatched = 0;

   // Reference model: the predictor's tables as plain arrays, indexed/tagged by arithmetic.
   bit          m_valid [NENT];
   int unsigned m_tag   [NENT];
   logic [31:0] m_tgt   [NENT];
   int          m_ctr   [NENT];
   logic [31:0] m_cnt;

   function automatic int unsigned midx(input logic [31:0] pc);
      return (pc / 4) % NENT;
   endfunction

   function automatic int unsigned mtag(input logic [31:0] pc);
      return pc / (4 * NENT);
   endfunction

   task automatic m_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
      int unsigned i;
      i  = midx(pc);
      tk = m_valid[i] && (m_tag[i] == mtag(pc)) && (m_ctr[i] >= 2);
      tg = tk ? m_tgt[i] : pc + 32'd4;
   endtask

   task automatic m_reset();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
         m_tag[i]   = 0;
         m_tgt[i]   = 32'd0;
      end
      m_cnt = 32'd0;
   endtask

   // One cycle: apply inputs, push expected outputs, then advance the model at the edge.
   task automatic cyc(input logic r, input logic [31:0] fpc, input logic rv,
                      input logic [31:0] rpc, input logic rt, input logic [31:0] rtg,
                      input logic rpt, input logic [31:0] rptg);
      exp_t e;
      int unsigned i;
      bit hit;
      rst = r;
      bif.fetchPC = fpc;
      bif.resolveValid = rv;
      bif.resolvePC = rpc;
      bif.resolveTaken = rt;
      bif.resolveTarget = rtg;
      bif.resolvePredTaken = rpt;
      bif.resolvePredTarget = rptg;
      m_predict(fpc, e.ptaken, e.ptarget);
      e.misp  = rv && ((rt != rpt) || (rt && (rptg != rtg)));
      e.redir = rt ? rtg : rpc + 32'd4;
      e.cnt   = m_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      if (r) begin
         m_reset();
      end else begin
         i = midx(rpc);
         hit = m_valid[i] && (m_tag[i] == mtag(rpc));
         if (rv && hit) begin
            m_ctr[i] = rt ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (rt) m_tgt[i] = rtg;
         end else if (rv && rt) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = mtag(rpc);
            m_tgt[i]   = rtg;
            m_ctr[i]   = 2;
         end
         if (e.misp) m_cnt = m_cnt + 32'd1;
      end
      #1;
   endtask

   task automatic fetch(input logic [31:0] fpc);
      cyc(1'b0, fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic resolve(input logic [31:0] fpc, input logic [31:0] rpc, input logic rt,
                          input logic [31:0] rtg, input logic rpt, input logic [31:0] rptg);
      cyc(1'b0, fpc, 1'b1, rpc, rt, rtg, rpt, rptg);
   endtask

   // Monitor: outputs are always presented, so one expectation is checked per cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         compared++;
         if (bif.predictTaken !== e.ptaken) begin
            mismatched++;
            $display("FAIL predictTaken pc=%h got=%b exp=%b", bif.fetchPC, bif.predictTaken, e.ptaken);
         end
         compared++;
         if (bif.predictTarget !== e.ptarget) begin
            mismatched++;
            $display("FAIL predictTarget pc=%h got=%h exp=%h", bif.fetchPC, bif.predictTarget, e.ptarget);
         end
         compared++;
         if (bif.mispredict !== e.misp) begin
            mismatched++;
            $display("FAIL mispredict rpc=%h got=%b exp=%b", bif.resolvePC, bif.mispredict, e.misp);
         end
         if (e.misp) begin
            compared++;
            if (bif.redirectPC !== e.redir) begin
               mismatched++;
               $display("FAIL redirectPC rpc=%h got=%h exp=%h", bif.resolvePC, bif.redirectPC, e.redir);
            end
         end
         compared++;
         if (bif.mispredictCount !== e.cnt) begin
            mismatched++;
            $display("FAIL mispredictCount got=%0d exp=%0d", bif.mispredictCount, e.cnt);
         end
      end
   end

   initial begin
      logic [31:0] rpc, rtg, ptg;
      logic        rt, ptk;
      int          waited;
      bif.fetchPC = 32'd0;
      bif.resolveValid = 1'b0;
      bif.resolvePC = 32'd0;
      bif.resolveTaken = 1'b0;
      bif.resolveTarget = 32'd0;
      bif.resolvePredTaken = 1'b0;
      bif.resolvePredTarget = 32'd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      m_reset();
      #1;

      fetch(32'h100);
      // First taken resolve with same-cycle lookup of the same PC.
      resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      fetch(32'h100);
      repeat (3) resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      fetch(32'h100);
      repeat (2) resolve(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      fetch(32'h100);
      repeat (2) resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      fetch(32'h100);
      resolve(32'h100, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
      fetch(32'h100);
      // Aliasing entry: same index, different tag.
      resolve(32'h200, 32'h200, 1'b1, 32'h40, 1'b0, 32'h204);
      fetch(32'h100);
      fetch(32'h200);
      fetch(32'h203);
      // Reset together with a resolve.
      cyc(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h44, 1'b0, 32'h304);
      fetch(32'h200);
      fetch(32'hFFFF_FFFC);

      for (int n = 0; n < 600; n++) begin
         rpc = ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         rt  = ($urandom_range(0, 3) != 0);
         rtg = {$urandom_range(0, 3), 4'h0} + 32'h1000;
         m_predict(rpc, ptk, ptg);
         if ($urandom_range(0, 5) == 0) ptk = ~ptk;
         if ($urandom_range(0, 7) == 0) ptg = rtg;
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2),
             ($urandom_range(0, 3) != 0), rpc, rt, rtg, ptk, ptg);
      end
      fetch(32'h0);

      waited = 0;
      while (sb_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (sb_q.size() > 0) begin
         mismatched++;
         $display("FAIL drain pending=%0d required=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
